// File: rtl/blk_mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and block-memory signals that meet at the arbiter.
// The slave modport is the arbiter's view; master is the caches/memory side.
interface blk_mem_arbiter_if #(
   parameter int BLK_W = 256
);
   logic              i_req;
   logic [31:0]       i_addr;
   logic [BLK_W-1:0]  i_blk;
   logic              i_done;

   logic              d_rd_req;
   logic              d_wr_req;
   logic [31:0]       d_addr;
   logic [BLK_W-1:0]  d_wr_blk;
   logic [BLK_W-1:0]  d_blk;
   logic              d_done;

   logic [31:0]       mem_addr;
   logic              mem_blk_read;
   logic              mem_blk_write;
   logic [BLK_W-1:0]  mem_blk_wdata;
   logic [BLK_W-1:0]  mem_blk_rdata;
   logic              mem_rd_valid;
   logic              mem_wr_valid;

   logic              busy;

   modport slave (
      input  i_req, i_addr,
      output i_blk, i_done,
      input  d_rd_req, d_wr_req, d_addr, d_wr_blk,
      output d_blk, d_done,
      output mem_addr, mem_blk_read, mem_blk_write, mem_blk_wdata,
      input  mem_blk_rdata, mem_rd_valid, mem_wr_valid,
      output busy
   );

   modport master (
      output i_req, i_addr,
      input  i_blk, i_done,
      output d_rd_req, d_wr_req, d_addr, d_wr_blk,
      input  d_blk, d_done,
      input  mem_addr, mem_blk_read, mem_blk_write, mem_blk_wdata,
      output mem_blk_rdata, mem_rd_valid, mem_wr_valid,
      input  busy
   );
endinterface

// File: rtl/blk_mem_arbiter.sv
// Shares the single block-memory port between I-cache refills and D-cache refills/write-backs,
// one transaction at a time: D write > D read > I read, with I forced through after STARVE_LIMIT D grants.
module blk_mem_arbiter #(
   parameter int STARVE_LIMIT = 3,
   parameter int BLK_W        = 256
) (
   input logic              CLK,
   input logic              RESET,
   blk_mem_arbiter_if.slave bus
);

   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [2:0] {
      IDLE,
      G_I,
      G_DRD,
      G_DWR,
      RESP
   } stateT;

   stateT             state;
   stateT             nextGrant;
   logic [CNT_W-1:0]  starveCnt;
   logic              starveHit;
   logic              dGrantWhileI;

   logic [31:0]       memAddr;
   logic              memRead;
   logic              memWrite;
   logic [BLK_W-1:0]  memWdata;
   logic [BLK_W-1:0]  iBlk;
   logic [BLK_W-1:0]  dBlk;
   logic              iDone;
   logic              dDone;
   logic              busyReg;

   // Winner of the next IDLE-cycle arbitration; a pending I that has waited out
   // STARVE_LIMIT D grants beats every D request.
   always_comb begin
      nextGrant    = IDLE;
      starveHit    = bus.i_req && (starveCnt >= STARVE_MAX);
      if (starveHit) begin
         nextGrant = G_I;
      end else if (bus.d_wr_req) begin
         nextGrant = G_DWR;
      end else if (bus.d_rd_req) begin
         nextGrant = G_DRD;
      end else if (bus.i_req) begin
         nextGrant = G_I;
      end
      dGrantWhileI = bus.i_req && ((nextGrant == G_DRD) || (nextGrant == G_DWR));
   end

   // Single FSM with every output registered. A grant is non-preemptive: once in a
   // G_* state only the matching memory valid moves it on, with no timeout.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         starveCnt <= '0;
         memAddr   <= '0;
         memRead   <= 1'b0;
         memWrite  <= 1'b0;
         memWdata  <= '0;
         iBlk      <= '0;
         dBlk      <= '0;
         iDone     <= 1'b0;
         dDone     <= 1'b0;
         busyReg   <= 1'b0;
      end else begin
         iDone <= 1'b0;
         dDone <= 1'b0;
         unique case (state)
            IDLE: begin
               state <= nextGrant;
               if (nextGrant != IDLE) begin
                  busyReg <= 1'b1;
               end
               case (nextGrant)
                  G_I: begin
                     memAddr   <= bus.i_addr;
                     memRead   <= 1'b1;
                     starveCnt <= '0;
                  end
                  G_DRD: begin
                     memAddr <= bus.d_addr;
                     memRead <= 1'b1;
                  end
                  G_DWR: begin
                     memAddr  <= bus.d_addr;
                     memWdata <= bus.d_wr_blk;
                     memWrite <= 1'b1;
                  end
                  default: begin
                  end
               endcase
               if (dGrantWhileI && (starveCnt < STARVE_MAX)) begin
                  starveCnt <= starveCnt + CNT_W'(1);
               end
            end
            G_I: begin
               if (bus.mem_rd_valid) begin
                  iBlk    <= bus.mem_blk_rdata;
                  memRead <= 1'b0;
                  iDone   <= 1'b1;
                  state   <= RESP;
               end
            end
            G_DRD: begin
               if (bus.mem_rd_valid) begin
                  dBlk    <= bus.mem_blk_rdata;
                  memRead <= 1'b0;
                  dDone   <= 1'b1;
                  state   <= RESP;
               end
            end
            G_DWR: begin
               if (bus.mem_wr_valid) begin
                  memWrite <= 1'b0;
                  dDone    <= 1'b1;
                  state    <= RESP;
               end
            end
            RESP: begin
               // The done pulse is visible for exactly this one cycle.
               busyReg <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.i_blk         = iBlk;
   assign bus.i_done        = iDone;
   assign bus.d_blk         = dBlk;
   assign bus.d_done        = dDone;
   assign bus.mem_addr      = memAddr;
   assign bus.mem_blk_read  = memRead;
   assign bus.mem_blk_write = memWrite;
   assign bus.mem_blk_wdata = memWdata;
   assign bus.busy          = busyReg;

endmodule
